// File: rtl/phy_pkg.sv
// phy_pkg: shared comma symbol, receiver state type and lane-width helper for the serial PHY
package phy_pkg;
  localparam logic [7:0] COMMA_BYTE = 8'hBC;
  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} rx_state_t;
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/s2p_shift.sv
// s2p_shift: serial-to-parallel shifter exposing the byte completed this edge and its byte phase
module s2p_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       clr,
  output logic [7:0] nxt,
  output logic       byte_done
);
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  assign nxt = {sr, din};
  assign byte_done = bit_cnt == 3'd7;
  // shift on every edge; the bit counter holds at zero while cleared so the next match sets phase
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= nxt[6:0];
      bit_cnt <= clr ? 3'd0 : bit_cnt + 3'd1;
    end
endmodule

// File: rtl/serial_rx_sync.sv
// serial_rx_sync: comma hunt, byte lock and lane-tagged deserializer; SYNC_LOSS_EN adds loss-of-sync detection
module serial_rx_sync import phy_pkg::*; #(
  parameter logic [7:0] COMMA = COMMA_BYTE,
  parameter int SYNC_COUNT = 4,
  parameter int LANES = 4
`ifdef SYNC_LOSS_EN
  , parameter int LOS_WINDOW = 64
`endif
) (
  input  logic                      clk_32f,
  input  logic                      reset,
  input  logic                      data_in,
  output logic [7:0]                data_out,
  output logic                      valid_out,
  output logic [lane_w(LANES)-1:0]  lane_out,
  output logic                      byte_strobe,
  output logic                      active
);
  localparam int LW = lane_w(LANES);
  localparam logic [3:0] SC = 4'(SYNC_COUNT);
  rx_state_t state, state_n;
  logic [3:0] bc_cnt, bc_n;
  logic [LW-1:0] lane_cnt, lane_n;
  logic [7:0] nxt;
  logic byte_done, hit, load, act_n;
`ifdef SYNC_LOSS_EN
  localparam int LB = $clog2(LOS_WINDOW + 1);
  logic [LB-1:0] los_cnt, los_n;
`endif
  s2p_shift u_s2p (.clk(clk_32f), .rst(reset), .din(data_in), .clr(state == HUNT), .nxt(nxt), .byte_done(byte_done));
  assign hit = nxt == COMMA;
  assign load = state == LOCKED && byte_done;
  // next state, aligned comma run, lane pointer and lock flag
  always_comb begin
    state_n = state;
    bc_n = bc_cnt;
    lane_n = lane_cnt;
    act_n = active;
`ifdef SYNC_LOSS_EN
    los_n = los_cnt;
`endif
    if (state == HUNT) begin
      if (hit) begin
        bc_n = 4'd1;
        state_n = SC == 4'd1 ? LOCKED : LOCKING;
        act_n = SC == 4'd1;
        lane_n = '0;
`ifdef SYNC_LOSS_EN
        los_n = '0;
`endif
      end
    end else if (state == LOCKING) begin
      if (byte_done) begin
        bc_n = hit ? bc_cnt + 4'd1 : 4'd0;
        state_n = !hit ? HUNT : (bc_n == SC ? LOCKED : LOCKING);
        act_n = hit && bc_n == SC;
        lane_n = '0;
`ifdef SYNC_LOSS_EN
        los_n = '0;
`endif
      end
    end else if (load) begin
      lane_n = lane_cnt + 1'b1;
`ifdef SYNC_LOSS_EN
      los_n = hit ? '0 : los_cnt + 1'b1;
      if (los_n == LB'(LOS_WINDOW)) begin
        state_n = HUNT;
        act_n = 1'b0;
        bc_n = '0;
        lane_n = '0;
        los_n = '0;
      end
`endif
    end
  end
  // state register plus byte outputs captured on each aligned byte while locked
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      state <= HUNT;
      bc_cnt <= '0;
      lane_cnt <= '0;
      active <= 1'b0;
      byte_strobe <= 1'b0;
      data_out <= '0;
      valid_out <= 1'b0;
      lane_out <= '0;
`ifdef SYNC_LOSS_EN
      los_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      bc_cnt <= bc_n;
      lane_cnt <= lane_n;
      active <= act_n;
      byte_strobe <= load;
`ifdef SYNC_LOSS_EN
      los_cnt <= los_n;
`endif
      if (load) begin
        data_out <= nxt;
        valid_out <= !hit;
        lane_out <= lane_cnt;
      end
    end
endmodule

// File: doc/serial_rx_sync.md
Name: serial_rx_sync

Overview:
- Receive end of the 4-lane serial PHY link.
- Takes the single-bit serial stream clocked at clk_32f, hunts for the 0xBC comma, and locks byte alignment after SYNC_COUNT consecutive commas.
- Once locked, it deserializes bytes, tags each with a lane index (0..LANES-1) and a valid flag, and raises active.
- Sits after the serial line, ahead of the per-lane demux/FIFO stage.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol; also marks an invalid lane slot.
- SYNC_COUNT, 4, consecutive aligned commas required to lock (min 1, max 15).
- LANES, 4, lanes interleaved per frame; a power of 2.
- LOS_WINDOW, 64, bytes without a comma before sync is declared lost (only with SYNC_LOSS_EN).

Ports:
- clk_32f  in  1  bit clock; one serial bit sampled per rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  1  serial data, MSB of each byte first.
- data_out  out  8  deserialized byte.
- valid_out  out  1  qualifies data_out; 1 when byte != COMMA.
- lane_out  out  $clog2(LANES)  lane index of data_out.
- byte_strobe  out  1  one-cycle pulse when data_out, valid_out and lane_out update.
- active  out  1  link locked.

Behaviour:
- Reset (async, high) clears all of the following, and they hold while reset is high:
  - outputs: data_out=0, valid_out=0, lane_out=0, byte_strobe=0, active=0;
  - internal state: state=HUNT, shift reg=0, bit_cnt=0, bc_cnt=0, lane_cnt=0.
- Shift register: sr <= {sr[6:0], data_in} on every edge in every state. nxt = {sr[6:0], data_in} is the byte completed this edge.
- HUNT:
  - Compare nxt to COMMA every edge (bit-by-bit search).
  - On a match: bit_cnt=0, bc_cnt=1. If SYNC_COUNT==1 go to LOCKED, otherwise go to LOCKING.
- LOCKING:
  - bit_cnt increments 0..7 and wraps.
  - When bit_cnt==7, evaluate nxt:
    - COMMA: bc_cnt++. When bc_cnt reaches SYNC_COUNT, go to LOCKED, set active=1 on that edge, lane_cnt=0.
    - Any other value: go to HUNT, bc_cnt=0. No strobe is emitted.
  - byte_strobe stays 0 throughout LOCKING.
- LOCKED:
  - When bit_cnt==7, on the same edge:
    - data_out<=nxt, valid_out<=(nxt!=COMMA), lane_out<=lane_cnt, byte_strobe<=1;
    - lane_cnt wraps modulo LANES.
  - On every other edge byte_strobe<=0; the other outputs hold.
  - The first byte after the locking comma is lane 0.
  - Commas in LOCKED are still strobed, with valid_out=0.
- Latency: outputs are visible after the edge that samples bit 0 (LSB) of the byte, i.e. 1 clk_32f after the last bit is presented.
- Strobe spacing: exactly 8 clk_32f while locked; LANES strobes per clk_f frame.
- active: rises on the locking edge. Without SYNC_LOSS_EN it falls only on reset.
- Reset mid-byte or mid-lock: immediate return to HUNT with all outputs cleared. The partial byte is discarded.
- Comma straddling a byte boundary in LOCKED: ignored; alignment is fixed once locked.

Optional Feature:
- Macro: SYNC_LOSS_EN.
- Defined:
  - A byte counter in LOCKED clears on each aligned COMMA and increments on each non-comma byte.
  - When it reaches LOS_WINDOW: go to HUNT, active<=0, bc_cnt=0, lane_cnt=0. That final byte is still strobed.
- Undefined: no counter; LOCKED is left only via reset.

Decomposition:
- Shared package phy_pkg:
  - COMMA_BYTE = 8'hBC;
  - state typedef rx_state_t {HUNT, LOCKING, LOCKED};
  - LANE_W = $clog2(LANES) helper.
- Sub-module s2p_shift:
  - contains the 8-bit shift register plus the 3-bit bit counter with sync clear;
  - outputs nxt and byte_done.
- The FSM, lane counter and output registers stay in serial_rx_sync.

Test Plan:
- Lock: after reset release, send 3 junk bits then four 8'hBC → active rises on the edge sampling the 4th BC's last bit; no byte_strobe before it.
- Data: after lock, send FF,EE,DD,CC → four strobes 8 cycles apart, lane_out 0,1,2,3, valid_out=1, data_out matches.
- Idle mix: send BC,BC,77,BC → valid_out 0,0,1,0, lane_out 0..3, data_out=77 on lane 2.
- Failed lock: BC,BC,5A,BC,BC,BC,BC → no lock after 5A; active rises only at the 4th consecutive BC after 5A; lane 0 is the next byte.
- Reset mid-byte: assert reset after 3 bits of a locked byte → all outputs 0 immediately; relock needs 4 fresh BCs.
- SYNC_LOSS_EN, LOS_WINDOW=4: after lock send 11,22,33,44 → 4th strobe seen, then active=0 and HUNT; a BC inside the window resets the count.
